l15_arbiter: RTL and testbench

L15_ARBITER -- requirements
Module: l15_arbiter

---
 rtl/l15_arbiter_pkg.sv | 41 ++++
 rtl/l15_arbiter_rr_pick.sv | 31 +++
 rtl/l15_arbiter.sv | 176 +++++++++++++++++
 tb/tb_l15_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/l15_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// l15_arbiter_pkg
// Shared definitions for the L1.5 request arbiter:
//   - L1.5 response returntype codes
//   - arbiter state and port-owner enums
//   - packed request bundle that is muxed onto the L1.5 request port
//   - helper that recognises the returntypes which complete a transaction
// ---------------------------------------------------------------------------
package l15_arbiter_pkg;

  localparam logic [3:0] LOAD_RET  = 4'b0000;
  localparam logic [3:0] IFILL_RET = 4'b0001;
  localparam logic [3:0] ST_ACK    = 4'b0100;
  localparam logic [3:0] INT_RET   = 4'b0111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_ACK,
    S_RESP
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_F,
    OWN_M
  } owner_e;

  typedef struct packed {
    logic [4:0]  rqtype;
    logic [2:0]  size;
    logic [31:0] address;
    logic [63:0] data;
  } l15_req_t;

  // Returntypes that close the single outstanding transaction.
  function automatic logic is_done_ret(input logic [3:0] rt);
    return (rt == LOAD_RET) || (rt == IFILL_RET) || (rt == ST_ACK);
  endfunction

endpackage

// File: rtl/l15_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// l15_rr_pick
// Two-way round-robin picker between the fetch and mem requesters.
// A lone requester always wins; on a tie the one not served last wins.
//   f_val   in  fetch request valid
//   m_val   in  mem request valid
//   last_m  in  1 = mem was the last owner served to completion
//   pick    out OWN_NONE when nobody requests, otherwise the chosen owner
// ---------------------------------------------------------------------------
module l15_rr_pick
  import l15_arbiter_pkg::*;
(
  input  logic   f_val,
  input  logic   m_val,
  input  logic   last_m,
  output owner_e pick
);

  logic grant_m;

  assign grant_m = m_val & (~f_val | ~last_m);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    pick = OWN_NONE;
    if (grant_m)    pick = OWN_M;
    else if (f_val) pick = OWN_F;
  end

endmodule

// File: rtl/l15_arbiter.sv
// ---------------------------------------------------------------------------
// l15_arbiter
// Shares one L1.5 request port between the fetch (f_*) and mem-stage (m_*)
// requesters. One transaction is outstanding at a time; owner selection is
// round-robin and only happens from IDLE once the core has been woken.
//
// Ports
//   clk, nrst                      clock, async active-low reset
//   f_rqtype/size/address/data/val fetch request (held stable until header ack)
//   f_header_ack/f_ack/f_resp_val  fetch handshake returns
//   m_rqtype/size/address/data/val mem request (held stable until header ack)
//   m_header_ack/m_ack/m_resp_val  mem handshake returns
//   transducer_l15_*               muxed request towards the L1.5
//   l15_transducer_header_ack/ack  L1.5 request acknowledgements
//   l15_transducer_val/returntype  L1.5 response
//   transducer_l15_req_ack         response consumed
//   arb_eqmem                      mem currently owns the port
//   memOp_done                     one-cycle pulse when a mem transaction ends
//   wake_up                        sticky core-awake flag
// ---------------------------------------------------------------------------
module l15_arbiter
  import l15_arbiter_pkg::*;
#(
  parameter logic [3:0] WAKE_RET  = INT_RET,
  parameter bit         MEM_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        nrst,

  input  logic [4:0]  f_rqtype,
  input  logic [2:0]  f_size,
  input  logic [31:0] f_address,
  input  logic [63:0] f_data,
  input  logic        f_val,
  output logic        f_header_ack,
  output logic        f_ack,
  output logic        f_resp_val,

  input  logic [4:0]  m_rqtype,
  input  logic [2:0]  m_size,
  input  logic [31:0] m_address,
  input  logic [63:0] m_data,
  input  logic        m_val,
  output logic        m_header_ack,
  output logic        m_ack,
  output logic        m_resp_val,

  output logic [4:0]  transducer_l15_rqtype,
  output logic [2:0]  transducer_l15_size,
  output logic [31:0] transducer_l15_address,
  output logic [63:0] transducer_l15_data,
  output logic        transducer_l15_val,
  input  logic        l15_transducer_header_ack,
  input  logic        l15_transducer_ack,

  input  logic        l15_transducer_val,
  input  logic [3:0]  l15_transducer_returntype,
  output logic        transducer_l15_req_ack,

  output logic        arb_eqmem,
  output logic        memOp_done,
  output logic        wake_up
);

  arb_state_e state;
  owner_e     owner;
  owner_e     pick;
  logic       last_m;
  logic       wake_q;

  logic       sel_f;
  logic       sel_m;
  logic       own_val;
  logic       issue;
  logic       hdr_fwd;
  logic       ack_fwd;
  logic       done_rsp;
  l15_req_t   req_mux;

  l15_rr_pick u_pick (
    .f_val  (f_val),
    .m_val  (m_val),
    .last_m (last_m),
    .pick   (pick)
  );

  assign sel_f   = (owner == OWN_F);
  assign sel_m   = (owner == OWN_M);
  assign own_val = (sel_f & f_val) | (sel_m & m_val);

  // The request is only presented while the owner still holds val, so an
  // owner that withdraws in REQ never reaches the L1.5.
  assign issue    = (state == S_REQ) & own_val;
  assign hdr_fwd  = issue & l15_transducer_header_ack;
  assign ack_fwd  = (hdr_fwd & l15_transducer_ack)
                  | ((state == S_WAIT_ACK) & l15_transducer_ack);
  assign done_rsp = (state == S_RESP) & l15_transducer_val
                  & is_done_ret(l15_transducer_returntype);

  always_comb begin
    req_mux = '0;
    if (issue) begin
      if (sel_m) req_mux = '{m_rqtype, m_size, m_address, m_data};
      else       req_mux = '{f_rqtype, f_size, f_address, f_data};
    end
  end

  assign transducer_l15_rqtype  = req_mux.rqtype;
  assign transducer_l15_size    = req_mux.size;
  assign transducer_l15_address = req_mux.address;
  assign transducer_l15_data    = req_mux.data;
  assign transducer_l15_val     = issue;

  assign f_header_ack = hdr_fwd  & sel_f;
  assign m_header_ack = hdr_fwd  & sel_m;
  assign f_ack        = ack_fwd  & sel_f;
  assign m_ack        = ack_fwd  & sel_m;
  assign f_resp_val   = done_rsp & sel_f;
  assign m_resp_val   = done_rsp & sel_m;
  assign memOp_done   = done_rsp & sel_m;

  // Every response is consumed: completions in RESP, everything else
  // (wake-ups, invalidations, leftovers of an aborted transaction) drained.
  assign transducer_l15_req_ack = l15_transducer_val;

  assign arb_eqmem = sel_m & (state != S_IDLE);
  assign wake_up   = wake_q;

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state  <= S_IDLE;
      owner  <= OWN_NONE;
      last_m <= !MEM_FIRST;
      wake_q <= 1'b0;
    end else begin
      if (l15_transducer_val && (l15_transducer_returntype == WAKE_RET))
        wake_q <= 1'b1;

      case (state)
        S_IDLE: begin
          if (wake_q && (pick != OWN_NONE)) begin
            owner <= pick;
            state <= S_REQ;
          end
        end
        S_REQ: begin
          if (!own_val) begin
            // Withdrawn before the header was taken: nothing issued and
            // the round-robin history stays as it was.
            owner <= OWN_NONE;
            state <= S_IDLE;
          end else if (l15_transducer_header_ack) begin
            state <= l15_transducer_ack ? S_RESP : S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          if (l15_transducer_ack) state <= S_RESP;
        end
        S_RESP: begin
          if (done_rsp) begin
            last_m <= sel_m;
            owner  <= OWN_NONE;
            state  <= S_IDLE;
          end
        end
        default: begin
          owner <= OWN_NONE;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l15_arbiter.sv
// ---------------------------------------------------------------------------
// tb_l15_arbiter
// Directed bench for l15_arbiter. Inputs change on the falling edge and
// outputs are sampled 1 time unit later, well away from the rising edge.
// Output flag vector order (MSB..LSB):
//   t_val | f_hdr f_ack f_rsp | m_hdr m_ack m_rsp | req_ack | eqmem | done | wake
// ---------------------------------------------------------------------------
module tb_l15_arbiter;
  import l15_arbiter_pkg::*;

  localparam logic [4:0]  F_RQ = 5'b01001;
  localparam logic [2:0]  F_SZ = 3'b011;
  localparam logic [31:0] F_AD = 32'h0000_1000;
  localparam logic [63:0] F_DT = 64'h1111_2222_3333_4444;
  localparam logic [4:0]  M_RQ = 5'b00000;
  localparam logic [2:0]  M_SZ = 3'b010;
  localparam logic [31:0] M_AD = 32'h4000_0100;
  localparam logic [63:0] M_DT = 64'hAAAA_BBBB_CCCC_DDDD;
  localparam logic [3:0]  INV_RET = 4'b0011;

  logic        clk = 1'b0;
  logic        nrst;
  logic        f_val, m_val;
  logic        hdr_ack, ack, rsp_val;
  logic [3:0]  rettype;

  logic        f_header_ack, f_ack, f_resp_val;
  logic        m_header_ack, m_ack, m_resp_val;
  logic [4:0]  t_rqtype;
  logic [2:0]  t_size;
  logic [31:0] t_address;
  logic [63:0] t_data;
  logic        t_val, req_ack, arb_eqmem, memop_done, wake_up;

  logic [10:0]  flags;
  logic [103:0] req_bus;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  l15_arbiter dut (
    .clk                       (clk),
    .nrst                      (nrst),
    .f_rqtype                  (F_RQ),
    .f_size                    (F_SZ),
    .f_address                 (F_AD),
    .f_data                    (F_DT),
    .f_val                     (f_val),
    .f_header_ack              (f_header_ack),
    .f_ack                     (f_ack),
    .f_resp_val                (f_resp_val),
    .m_rqtype                  (M_RQ),
    .m_size                    (M_SZ),
    .m_address                 (M_AD),
    .m_data                    (M_DT),
    .m_val                     (m_val),
    .m_header_ack              (m_header_ack),
    .m_ack                     (m_ack),
    .m_resp_val                (m_resp_val),
    .transducer_l15_rqtype     (t_rqtype),
    .transducer_l15_size       (t_size),
    .transducer_l15_address    (t_address),
    .transducer_l15_data       (t_data),
    .transducer_l15_val        (t_val),
    .l15_transducer_header_ack (hdr_ack),
    .l15_transducer_ack        (ack),
    .l15_transducer_val        (rsp_val),
    .l15_transducer_returntype (rettype),
    .transducer_l15_req_ack    (req_ack),
    .arb_eqmem                 (arb_eqmem),
    .memOp_done                (memop_done),
    .wake_up                   (wake_up)
  );

  assign flags   = {t_val, f_header_ack, f_ack, f_resp_val,
                    m_header_ack, m_ack, m_resp_val,
                    req_ack, arb_eqmem, memop_done, wake_up};
  assign req_bus = {t_rqtype, t_size, t_address, t_data};

  typedef struct {
    string      name;
    logic       fv, mv, ha, a, rv;
    logic [3:0] rt;
    logic [10:0] exp_flags;
    int         sel;          // 0: no request on the port, 1: fetch, 2: mem
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input string n, input logic fv, mv, ha, a, rv,
                              input logic [3:0] rt, input logic [10:0] e,
                              input int sel);
    vec_t v;
    v.name = n; v.fv = fv; v.mv = mv; v.ha = ha; v.a = a; v.rv = rv;
    v.rt = rt; v.exp_flags = e; v.sel = sel;
    return v;
  endfunction

  function automatic logic [103:0] exp_req(input int sel);
    if (sel == 1) return {F_RQ, F_SZ, F_AD, F_DT};
    if (sel == 2) return {M_RQ, M_SZ, M_AD, M_DT};
    return '0;
  endfunction

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input logic fv, mv, ha, a, rv, input logic [3:0] rt);
    @(negedge clk);
    f_val = fv; m_val = mv; hdr_ack = ha; ack = a; rsp_val = rv; rettype = rt;
    #1;
  endtask

  task automatic expect_out(input string name, input logic [10:0] ef,
                            input int sel);
    check({name, "/flags"}, {117'b0, flags}, {117'b0, ef});
    check({name, "/req"}, {24'b0, req_bus}, {24'b0, exp_req(sel)});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    nrst = 1'b0;
    f_val = 0; m_val = 0; hdr_ack = 0; ack = 0; rsp_val = 0; rettype = 4'h0;

    // Wake-up gating with both requesters pending, then the round-robin
    // tie (fetch first after reset), then the mem transaction.
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk($sformatf("nowake%0d", i), 1, 1, 0, 0, 0, 4'h0, 11'b0_000_000_0_0_0_0, 0));
    tbl.push_back(mk("wake_rsp",    1, 1, 0, 0, 1, INT_RET,   11'b0_000_000_1_0_0_0, 0));
    tbl.push_back(mk("grant_f",     1, 1, 0, 0, 0, 4'h0,      11'b0_000_000_0_0_0_1, 0));
    tbl.push_back(mk("f_issue",     1, 1, 0, 0, 0, 4'h0,      11'b1_000_000_0_0_0_1, 1));
    tbl.push_back(mk("f_hdr_ack",   1, 1, 1, 1, 0, 4'h0,      11'b1_110_000_0_0_0_1, 1));
    tbl.push_back(mk("f_resp_wait", 0, 1, 0, 0, 0, 4'h0,      11'b0_000_000_0_0_0_1, 0));
    tbl.push_back(mk("f_ifill",     0, 1, 0, 0, 1, IFILL_RET, 11'b0_001_000_1_0_0_1, 0));
    tbl.push_back(mk("grant_m",     0, 1, 0, 0, 0, 4'h0,      11'b0_000_000_0_0_0_1, 0));
    tbl.push_back(mk("m_issue",     0, 1, 0, 0, 0, 4'h0,      11'b1_000_000_0_1_0_1, 2));
    tbl.push_back(mk("m_hdr_ack",   0, 1, 1, 1, 0, 4'h0,      11'b1_000_110_0_1_0_1, 2));
    tbl.push_back(mk("m_resp_wait", 0, 0, 0, 0, 0, 4'h0,      11'b0_000_000_0_1_0_1, 0));
    tbl.push_back(mk("m_load",      0, 0, 0, 0, 1, LOAD_RET,  11'b0_000_001_1_1_1_1, 0));
    tbl.push_back(mk("m_idle",      0, 0, 0, 0, 0, 4'h0,      11'b0_000_000_0_0_0_1, 0));

    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", 11'b0, 0);
    @(negedge clk);
    nrst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].fv, tbl[i].mv, tbl[i].ha, tbl[i].a, tbl[i].rv, tbl[i].rt);
      expect_out(tbl[i].name, tbl[i].exp_flags, tbl[i].sel);
    end

    // Header ack alone, data ack three cycles later through WAIT_ACK.
    apply(1, 0, 0, 0, 0, 4'h0);     expect_out("wa_grant", 11'b0_000_000_0_0_0_1, 0);
    apply(1, 0, 1, 0, 0, 4'h0);     expect_out("wa_hdr",   11'b1_100_000_0_0_0_1, 1);
    apply(0, 0, 0, 0, 0, 4'h0);     expect_out("wa_wait1", 11'b0_000_000_0_0_0_1, 0);
    apply(0, 0, 0, 0, 0, 4'h0);     expect_out("wa_wait2", 11'b0_000_000_0_0_0_1, 0);
    apply(0, 0, 0, 1, 0, 4'h0);     expect_out("wa_ack",   11'b0_010_000_0_0_0_1, 0);
    apply(0, 0, 0, 0, 1, LOAD_RET); expect_out("wa_resp",  11'b0_001_000_1_0_0_1, 0);

    // Invalidation in RESP is drained; only the load completes the op.
    apply(0, 1, 0, 0, 0, 4'h0);     expect_out("inv_grant", 11'b0_000_000_0_0_0_1, 0);
    apply(0, 1, 1, 1, 0, 4'h0);     expect_out("inv_hdr",   11'b1_000_110_0_1_0_1, 2);
    apply(0, 0, 0, 0, 1, INV_RET);  expect_out("inv_drop",  11'b0_000_000_1_1_0_1, 0);
    apply(0, 0, 0, 0, 1, LOAD_RET); expect_out("inv_load",  11'b0_000_001_1_1_1_1, 0);

    // Mem withdraws in REQ; pending fetch is granted from the next IDLE.
    apply(0, 1, 0, 0, 0, 4'h0);     expect_out("wd_grant_m", 11'b0_000_000_0_0_0_1, 0);
    apply(1, 0, 0, 0, 0, 4'h0);     expect_out("wd_drop",    11'b0_000_000_0_1_0_1, 0);
    apply(1, 0, 0, 0, 0, 4'h0);     expect_out("wd_idle",    11'b0_000_000_0_0_0_1, 0);
    apply(1, 0, 0, 0, 0, 4'h0);     expect_out("wd_f_issue", 11'b1_000_000_0_0_0_1, 1);
    apply(1, 0, 1, 0, 0, 4'h0);     expect_out("wd_f_hdr",   11'b1_100_000_0_0_0_1, 1);
    apply(0, 0, 0, 0, 0, 4'h0);     expect_out("rst_pre",    11'b0_000_000_0_0_0_1, 0);

    // Asynchronous reset while in WAIT_ACK, then drain the late response.
    #2 nrst = 1'b0;
    #1 expect_out("rst_async", 11'b0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    apply(0, 0, 0, 0, 1, LOAD_RET); expect_out("rst_drain",  11'b0_000_000_1_0_0_0, 0);
    apply(0, 0, 0, 0, 0, 4'h0);     expect_out("rst_quiet",  11'b0, 0);
    apply(1, 0, 0, 0, 0, 4'h0);     expect_out("rst_nowake", 11'b0, 0);
    apply(1, 0, 0, 0, 0, 4'h0);     expect_out("rst_nogrant", 11'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
